operand_issue_stage: RTL

- Execute-feeding stage of the pipelined CPU: decodes a 16-bit instruction, reads a 4-entry register file, and drives the combinational ALU's alu_op/op1/op2 from a registered EX stage.
- Takes the ALU result back and writes it to the register file on the next edge.
- Forwards the in-flight ALU result to dependent instructions, so back-to-back dependencies need no stall.

---
 rtl/operand_issue_stage_if.sv | 31 +++
 rtl/operand_issue_stage.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/operand_issue_stage_if.sv
// Bundle of the operand issue stage: instruction handshake, EX outputs to the ALU,
// ALU result return path and register-file debug read port.
interface operand_issue_stage_if #(
  parameter int WIDTH    = 7,
  parameter int OP_WIDTH = 3
);
  logic                in_valid;
  logic                in_ready;
  logic [15:0]         instr;
  logic                stall;
  logic                flush;
  logic [WIDTH:0]      alu_result;
  logic [OP_WIDTH-1:0] alu_op;
  logic [WIDTH-1:0]    op1;
  logic [WIDTH-1:0]    op2;
  logic                ex_valid;
  logic [1:0]          ex_rd;
  logic                carry_flag;
  logic [1:0]          dbg_sel;
  logic [WIDTH-1:0]    dbg_data;

  modport master (
    output in_valid, instr, stall, flush, alu_result, dbg_sel,
    input  in_ready, alu_op, op1, op2, ex_valid, ex_rd, carry_flag, dbg_data
  );

  modport slave (
    input  in_valid, instr, stall, flush, alu_result, dbg_sel,
    output in_ready, alu_op, op1, op2, ex_valid, ex_rd, carry_flag, dbg_data
  );
endinterface

// File: rtl/operand_issue_stage.sv
// Decode + register read + registered EX stage feeding a combinational ALU, with EX forwarding.
// Optional carry flag register enabled by defining OPERAND_ISSUE_CARRY_EN.
module operand_issue_stage #(
  parameter int WIDTH    = 7,
  parameter int OP_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_issue_stage_if.slave io
);

  // Opcodes 001..101 produce a result; 000, 110, 111 are NOPs.
  function automatic logic is_writer(input logic [OP_WIDTH-1:0] op);
    return (op != '0) && (op < OP_WIDTH'(6));
  endfunction

  function automatic logic [WIDTH-1:0] ext_imm(input logic [6:0] imm);
    logic [WIDTH+6:0] wide;
    wide = {{WIDTH{1'b0}}, imm};
    return wide[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0]    rf_q [4];

  logic                vld_p1;
  logic [OP_WIDTH-1:0] alu_op_p1;
  logic [WIDTH-1:0]    op1_p1;
  logic [WIDTH-1:0]    op2_p1;
  logic [1:0]          ex_rd_p1;

  logic                fire;
  logic                ex_load;
  logic                fwd_live;
  logic                wb_en;
  logic [WIDTH-1:0]    fwd_data;

  logic [OP_WIDTH-1:0] op_p0;
  logic [1:0]          rd_p0;
  logic [1:0]          rs1_p0;
  logic [1:0]          rs2_p0;
  logic                imm_sel_p0;
  logic [WIDTH-1:0]    src1_p0;
  logic [WIDTH-1:0]    src2_p0;
  logic [WIDTH-1:0]    op2_p0;

  logic                instr_unused;

  assign io.in_ready = !io.stall && !io.flush;
  assign fire        = io.in_valid && io.in_ready;
  // Flush forces a bubble even while stalled.
  assign ex_load     = io.flush || !io.stall;

  assign fwd_live = vld_p1 && is_writer(alu_op_p1);
  assign fwd_data = io.alu_result[WIDTH-1:0];
  assign wb_en    = !io.stall && !io.flush && fwd_live && (ex_rd_p1 != 2'd0);

  assign instr_unused = io.instr[7];

  // ---- p0: decode and operand select ----
  always_comb begin
    op_p0      = OP_WIDTH'(io.instr[15:13]);
    imm_sel_p0 = io.instr[12];
    rd_p0      = io.instr[11:10];
    rs1_p0     = io.instr[9:8];
    rs2_p0     = io.instr[1:0];

    // The EX result is exactly what gets written at this edge, so taking it here
    // gives dependent instructions the up-to-date value without a stall.
    src1_p0 = rf_q[rs1_p0];
    if (fwd_live && (ex_rd_p1 == rs1_p0))
      src1_p0 = fwd_data;
    if (rs1_p0 == 2'd0)
      src1_p0 = '0;

    src2_p0 = rf_q[rs2_p0];
    if (fwd_live && (ex_rd_p1 == rs2_p0))
      src2_p0 = fwd_data;
    if (rs2_p0 == 2'd0)
      src2_p0 = '0;

    op2_p0 = imm_sel_p0 ? ext_imm(io.instr[6:0]) : src2_p0;
  end

  // ---- p1: EX registers presented to the ALU ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      alu_op_p1 <= '0;
      op1_p1    <= '0;
      op2_p1    <= '0;
      ex_rd_p1  <= '0;
    end else if (ex_load) begin
      vld_p1    <= fire;
      alu_op_p1 <= fire ? op_p0   : '0;
      op1_p1    <= fire ? src1_p0 : '0;
      op2_p1    <= fire ? op2_p0  : '0;
      ex_rd_p1  <= fire ? rd_p0   : '0;
    end
  end

  // ---- writeback: ALU result into the register file ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++)
        rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[ex_rd_p1] <= fwd_data;
    end
  end

`ifdef OPERAND_ISSUE_CARRY_EN
  logic carry_q;
  logic carry_en;

  // Carry tracks ADD/SUB writebacks, including those aimed at r0.
  assign carry_en = !io.stall && !io.flush && vld_p1 &&
                    ((alu_op_p1 == OP_WIDTH'(1)) || (alu_op_p1 == OP_WIDTH'(2)));

  always_ff @(posedge clk) begin
    if (rst)
      carry_q <= 1'b0;
    else if (carry_en)
      carry_q <= io.alu_result[WIDTH];
  end

  assign io.carry_flag = carry_q;
`else
  logic carry_unused;
  assign carry_unused  = io.alu_result[WIDTH];
  assign io.carry_flag = 1'b0;
`endif

  assign io.ex_valid = vld_p1;
  assign io.alu_op   = alu_op_p1;
  assign io.op1      = op1_p1;
  assign io.op2      = op2_p1;
  assign io.ex_rd    = ex_rd_p1;
  assign io.dbg_data = (io.dbg_sel == 2'd0) ? '0 : rf_q[io.dbg_sel];

endmodule
